sign_narrower: RTL and testbench
================================

# sign_narrower

Narrows 32-bit register values to 16-bit halfword results for the store/halfword-write path, the inverse of the 16→32 immediate/load sign extension. Checks range in signed or unsigned mode and flags overflow per result. Keeps a sticky overflow flag and a saturating overflow counter. Sits between the ALU result bus and the data-memory halfword writer, with valid/ready handshakes on both sides and a 2-entry skid buffer.

## Interface
- IN_W, 32, input data width
- OUT_W, 16, output data width (OUT_W < IN_W)
- CNT_W, 16, overflow counter width
- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  producer has a word on `a`
- in_ready  out  1  block can accept; registered
- a  in  IN_W  value to narrow
- in_signed  in  1  1: signed range check; 0: unsigned; sampled with `a`
- out_valid  out  1  `b`/`ovf` hold a result
- out_ready  in  1  consumer takes result
- b  out  OUT_W  narrowed value
- ovf  out  1  overflow flag for the word on `b`
- ovf_sticky  out  1  set by any accepted overflowing word
- ovf_count  out  CNT_W  number of accepted overflowing words, saturating
- clr  in  1  synchronous clear of `ovf_sticky` and `ovf_count`

## Operation
- Accept occurs on a cycle with in_valid && in_ready. Deliver occurs on a cycle with out_valid && out_ready.
- Signed fit: a[IN_W-1:OUT_W-1] is all zeros or all ones. Unsigned fit: a[IN_W-1:OUT_W] == 0. ovf = !fit. Overflow is computed at accept and stored with the word.
- Default (wrap) result: b = a[OUT_W-1:0] regardless of ovf.
- Storage is a 2-entry FIFO (skid buffer). State is the occupancy, held in a registered state machine:
  - EMPTY: accept → ONE.
  - ONE: accept with no deliver → TWO; deliver with no accept → EMPTY; accept and deliver together → ONE.
  - TWO: deliver → ONE. No accept is possible because in_ready is 0.
- in_ready = (state != TWO). out_valid = (state != EMPTY). Output order equals input order.
- On an accepted word with ovf=1: ovf_sticky ← 1, and ovf_count ← ovf_count+1 unless it is already all-ones, in which case it holds.
- clr on the same cycle as an overflowing accept: the clear applies first and the accept then counts, giving ovf_count=1 and ovf_sticky=1.
- in_signed, a, and in_valid changes while in_ready=0 have no effect.

## Timing
- Reset (rst_n=0 at an edge) forces: state=EMPTY, in_ready=1, out_valid=0, b=0, ovf=0, ovf_sticky=0, ovf_count=0.
- Reset mid-operation discards buffered words. No partial deliver occurs.
- Latency is 1 cycle: a word accepted at edge N is on b/out_valid after edge N.
- Throughput is 1 word/cycle while out_ready=1.
- out_ready low for k≥2 cycles with in_valid high: 2 words are accepted, then in_ready=0 after the second accept edge.
- in_ready rises 1 edge after the first deliver from TWO.
- b/ovf stay stable while out_valid=1 and out_ready=0.
- All outputs come from registers. There is no combinational path from inputs to outputs.

## Configuration
- SIGN_NARROWER_SAT_EN defined: an overflowing word saturates instead of wrapping.
  - Signed: negative a gives 0x8000 (MSB=1, rest 0); positive a gives 0x7FFF.
  - Unsigned: gives all-ones, 0xFFFF.
  - ovf and counters behave the same as without the macro.
- Not defined: wrap (truncate) behaviour only. No saturation logic is compiled in.

## Test plan
- Signed, out_ready=1: a=10 → b=0x000A, ovf=0; a=-10 (0xFFFFFFF6) → b=0xFFF6, ovf=0; each result appears 1 cycle after accept.
- Signed overflow: a=0x00012345 → ovf=1, b=0x2345 (wrap) or 0x7FFF (SAT). a=0xFFFF7FFF → ovf=1, b=0x7FFF (wrap) or 0x8000 (SAT). Afterwards ovf_sticky=1 and ovf_count=2.
- Unsigned: a=0x0000FFFF → b=0xFFFF, ovf=0. a=0x00010000 → ovf=1, b=0x0000 (wrap) or 0xFFFF (SAT).
- Backpressure: send 88, -100, 5 back-to-back with out_ready=0 → in_ready=0 after 2 accepts. Release out_ready → outputs are 0x0058, 0xFF9C, then 0x0005 once accepted, in that order with no loss or duplication.
- Counter and clr: with CNT_W=2, send 5 overflowing words → ovf_count stays at 3. Then clr together with an overflowing accept → ovf_count=1, ovf_sticky=1.
- Reset mid-operation: with TWO words buffered, pulse rst_n=0 for 1 edge → out_valid=0, in_ready=1, ovf_count=0, and no stale word ever appears on b.

Source files
------------

// File: rtl/sign_narrower.sv
// -----------------------------------------------------------------------------
// sign_narrower
//
// Narrows IN_W-bit register values to OUT_W-bit halfword results for the
// store / halfword-write path (the inverse of 16->32 sign/zero extension).
// Each accepted word is range-checked in signed or unsigned mode; the
// overflow flag travels with the narrowed word through a 2-entry skid buffer.
// A sticky overflow flag and a saturating overflow counter summarise all
// accepted overflowing words.
//
// Build option:
//   SIGN_NARROWER_SAT_EN  defined     -> overflowing words saturate
//                                        (signed: 0x8000 / 0x7FFF,
//                                         unsigned: all ones)
//                         not defined -> overflowing words wrap (truncate)
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst_n       in   1      synchronous active-low reset
//   in_valid    in   1      producer has a word on a
//   in_ready    out  1      block can accept (registered)
//   a           in   IN_W   value to narrow
//   in_signed   in   1      1: signed range check, 0: unsigned
//   out_valid   out  1      b/ovf hold a result
//   out_ready   in   1      consumer takes the result
//   b           out  OUT_W  narrowed value
//   ovf         out  1      overflow flag belonging to b
//   ovf_sticky  out  1      set by any accepted overflowing word
//   ovf_count   out  CNT_W  accepted overflowing words, saturating
//   clr         in   1      synchronous clear of ovf_sticky / ovf_count
// -----------------------------------------------------------------------------
module sign_narrower #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  a,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] b,
    output logic             ovf,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             clr
);

    // Occupancy of the skid buffer.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Head entry drives the outputs directly; tail entry holds the second word.
    logic             r_in_ready;
    logic             r_out_valid;
    logic [OUT_W-1:0] r_head_b;
    logic             r_head_ovf;
    logic [OUT_W-1:0] r_tail_b;
    logic             r_tail_ovf;
    logic             r_sticky;
    logic [CNT_W-1:0] r_count;

    logic             w_accept;
    logic             w_deliver;
    logic             w_load_head;
    logic             w_load_tail;
    logic             w_shift;

    // -------------------------------------------------------------------------
    // Range check and narrowing of the incoming word
    // -------------------------------------------------------------------------
    // Signed fit: every bit from the MSB down to the new sign bit is a copy
    // of the sign. Unsigned fit: every bit above the result is zero.
    logic [IN_W-OUT_W:0]   w_upper_s;
    logic [IN_W-OUT_W-1:0] w_upper_u;
    logic                  w_fit_s;
    logic                  w_fit_u;
    logic                  w_ovf;
    logic [OUT_W-1:0]      w_result;

    assign w_upper_s = a[IN_W-1:OUT_W-1];
    assign w_upper_u = a[IN_W-1:OUT_W];
    assign w_fit_s   = (w_upper_s == '0) || (w_upper_s == '1);
    assign w_fit_u   = (w_upper_u == '0);
    assign w_ovf     = in_signed ? !w_fit_s : !w_fit_u;

`ifdef SIGN_NARROWER_SAT_EN
    localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

    always_comb begin
        w_result = a[OUT_W-1:0];
        if (w_ovf) begin
            if (in_signed) begin
                // The sign of the full-width value picks the clamp direction.
                w_result = a[IN_W-1] ? SAT_NEG : SAT_POS;
            end else begin
                w_result = '1;
            end
        end
    end
`else
    assign w_result = a[OUT_W-1:0];
`endif

    // -------------------------------------------------------------------------
    // Handshakes
    // -------------------------------------------------------------------------
    assign w_accept  = in_valid && r_in_ready;
    assign w_deliver = r_out_valid && out_ready;

    // -------------------------------------------------------------------------
    // Occupancy FSM: next state and data-movement strobes
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first so no path through
    // the case statement leaves it unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_load_head = 1'b0;
        w_load_tail = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = S_ONE;
                    w_load_head = 1'b1;
                end
            end
            S_ONE: begin
                case ({w_accept, w_deliver})
                    2'b10: begin
                        w_state_nxt = S_TWO;
                        w_load_tail = 1'b1;
                    end
                    2'b01: begin
                        w_state_nxt = S_EMPTY;
                    end
                    2'b11: begin
                        // Head leaves and the new word replaces it in place.
                        w_load_head = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            S_TWO: begin
                // in_ready is low here, so only a deliver can happen.
                if (w_deliver) begin
                    w_state_nxt = S_ONE;
                    w_shift     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register, registered handshake outputs and head entry
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_head_b    <= '0;
            r_head_ovf  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            // Handshake flags are decoded from the next state so they leave
            // the block straight from flops.
            r_in_ready  <= (w_state_nxt != S_TWO);
            r_out_valid <= (w_state_nxt != S_EMPTY);
            if (w_load_head) begin
                r_head_b   <= w_result;
                r_head_ovf <= w_ovf;
            end else if (w_shift) begin
                r_head_b   <= r_tail_b;
                r_head_ovf <= r_tail_ovf;
            end
        end
    end

    // NOTE: the tail entry is pure storage and is never reset; it is only
    // observable after being written, because occupancy gates its use.
    always_ff @(posedge clk) begin
        if (w_load_tail) begin
            r_tail_b   <= w_result;
            r_tail_ovf <= w_ovf;
        end
    end

    // -------------------------------------------------------------------------
    // Sticky flag and saturating overflow counter
    // -------------------------------------------------------------------------
    // clr is applied first, so a clear coinciding with an overflowing accept
    // leaves the counter at one and the sticky flag set.
    logic [CNT_W-1:0] w_cnt_base;
    logic             w_sticky_base;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_cnt_base    = clr ? '0 : r_count;
    assign w_sticky_base = clr ? 1'b0 : r_sticky;
    assign w_cnt_inc     = (&w_cnt_base) ? w_cnt_base : (w_cnt_base + CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
            r_count  <= '0;
        end else if (w_accept && w_ovf) begin
            r_sticky <= 1'b1;
            r_count  <= w_cnt_inc;
        end else begin
            r_sticky <= w_sticky_base;
            r_count  <= w_cnt_base;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all straight from registers)
    // -------------------------------------------------------------------------
    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign b          = r_head_b;
    assign ovf        = r_head_ovf;
    assign ovf_sticky = r_sticky;
    assign ovf_count  = r_count;

endmodule

// File: tb/tb_sign_narrower.sv
// -----------------------------------------------------------------------------
// tb_sign_narrower
//
// Self-checking bench for sign_narrower (IN_W=32, OUT_W=16, CNT_W=2).
// A table of vectors is applied with out_ready=1; a negedge monitor pushes the
// model result of every accepted word onto a queue and pops/compares it on
// every deliver. Hand-written sequences cover backpressure, clr and reset.
// -----------------------------------------------------------------------------
module tb_sign_narrower;

    localparam int IN_W  = 32;
    localparam int OUT_W = 16;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  a;
    logic             in_signed;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] b;
    logic             ovf;
    logic             ovf_sticky;
    logic [CNT_W-1:0] ovf_count;
    logic             clr;

    int n_checks = 0;
    int n_errors = 0;

    sign_narrower #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .in_signed  (in_signed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .b          (b),
        .ovf        (ovf),
        .ovf_sticky (ovf_sticky),
        .ovf_count  (ovf_count),
        .clr        (clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model written with signed arithmetic on the full value.
    function automatic logic [16:0] model(input logic [31:0] val, input logic sgn);
        logic        m_ovf;
        logic [15:0] m_b;
        if (sgn) m_ovf = ($signed(val) > 32767) || ($signed(val) < -32768);
        else     m_ovf = (val > 32'd65535);
        m_b = val[15:0];
`ifdef SIGN_NARROWER_SAT_EN
        if (m_ovf) begin
            if (sgn) m_b = ($signed(val) < 0) ? 16'h8000 : 16'h7FFF;
            else     m_b = 16'hFFFF;
        end
`endif
        return {m_ovf, m_b};
    endfunction

    // Scoreboard monitor: inputs change just after posedge, so at negedge the
    // handshake signals already hold the values the next edge will see.
    logic [16:0] sb_q[$];

    always @(negedge clk) begin
        logic [16:0] exp_item;
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_output", {15'd0, ovf, b}, 32'h1_DEAD);
                end else begin
                    exp_item = sb_q.pop_front();
                    check("sb_b",   {16'd0, b},   {16'd0, exp_item[15:0]});
                    check("sb_ovf", {31'd0, ovf}, {31'd0, exp_item[16]});
                end
            end
            if (in_valid && in_ready) sb_q.push_back(model(a, in_signed));
        end
    end

    // Watchdog keeps the run bounded.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] va;
        logic        sgn;
        logic [15:0] exp_b;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // Expected values written out by hand from the narrowing rules.
        vecs[0] = '{32'h0000_000A, 1'b1, 16'h000A, 1'b0};
        vecs[1] = '{32'hFFFF_FFF6, 1'b1, 16'hFFF6, 1'b0};
`ifdef SIGN_NARROWER_SAT_EN
        vecs[2] = '{32'h0001_2345, 1'b1, 16'h7FFF, 1'b1};
        vecs[3] = '{32'hFFFF_7FFF, 1'b1, 16'h8000, 1'b1};
`else
        vecs[2] = '{32'h0001_2345, 1'b1, 16'h2345, 1'b1};
        vecs[3] = '{32'hFFFF_7FFF, 1'b1, 16'h7FFF, 1'b1};
`endif
        vecs[4] = '{32'h0000_7FFF, 1'b1, 16'h7FFF, 1'b0};
        vecs[5] = '{32'hFFFF_8000, 1'b1, 16'h8000, 1'b0};
        vecs[6] = '{32'h0000_FFFF, 1'b0, 16'hFFFF, 1'b0};
`ifdef SIGN_NARROWER_SAT_EN
        vecs[7] = '{32'h0001_0000, 1'b0, 16'hFFFF, 1'b1};
        vecs[8] = '{32'h0000_8000, 1'b1, 16'h7FFF, 1'b1};
`else
        vecs[7] = '{32'h0001_0000, 1'b0, 16'h0000, 1'b1};
        vecs[8] = '{32'h0000_8000, 1'b1, 16'h8000, 1'b1};
`endif
        vecs[9] = '{32'hFFFF_FFFF, 1'b0, 16'hFFFF, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; in_signed = 1'b0;
        out_ready = 1'b0; clr = 1'b0;
        tick(); tick();
        check("rst_in_ready",  {31'd0, in_ready},   32'd1);
        check("rst_out_valid", {31'd0, out_valid},  32'd0);
        check("rst_b",         {16'd0, b},          32'd0);
        check("rst_ovf",       {31'd0, ovf},        32'd0);
        check("rst_sticky",    {31'd0, ovf_sticky}, 32'd0);
        check("rst_count",     {30'd0, ovf_count},  32'd0);
        rst_n = 1'b1;
        tick();

        // ---- table-driven vectors, one word per cycle, out_ready high ----
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'b1;
            a         = vecs[i].va;
            in_signed = vecs[i].sgn;
            check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            tick();
            check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("vec%0d_b", i),     {16'd0, b},         {16'd0, vecs[i].exp_b});
            check($sformatf("vec%0d_ovf", i),   {31'd0, ovf},       {31'd0, vecs[i].exp_ovf});
            if (i == 3) begin
                check("sticky_after_signed", {31'd0, ovf_sticky}, 32'd1);
                check("count_after_signed",  {30'd0, ovf_count},  32'd2);
            end
        end
        in_valid = 1'b0;
        tick();
        check("drain_out_valid", {31'd0, out_valid}, 32'd0);
        // Five overflowing words with a 2-bit counter: saturates at 3.
        check("count_saturated", {30'd0, ovf_count}, 32'd3);

        // ---- clr together with an overflowing accept ----
        clr = 1'b1; in_valid = 1'b1; a = 32'h0001_0000; in_signed = 1'b0;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        check("clr_accept_count",  {30'd0, ovf_count},  32'd1);
        check("clr_accept_sticky", {31'd0, ovf_sticky}, 32'd1);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_count",  {30'd0, ovf_count},  32'd0);
        check("clr_sticky", {31'd0, ovf_sticky}, 32'd0);

        // ---- backpressure: 88, -100, 5 with out_ready low ----
        out_ready = 1'b0; in_valid = 1'b1; in_signed = 1'b1;
        a = 32'd88;
        tick();
        check("bp_ready_after1", {31'd0, in_ready}, 32'd1);
        a = 32'hFFFF_FF9C;
        tick();
        check("bp_ready_after2", {31'd0, in_ready}, 32'd0);
        check("bp_b_head",       {16'd0, b},        32'h0058);
        a = 32'd5;
        tick();
        check("bp_stall_ready",  {31'd0, in_ready}, 32'd0);
        check("bp_stall_b",      {16'd0, b},        32'h0058);
        out_ready = 1'b1;
        tick();
        check("bp_ready_rise",   {31'd0, in_ready}, 32'd1);
        check("bp_b_second",     {16'd0, b},        32'hFF9C);
        tick();
        in_valid = 1'b0;
        check("bp_b_third",      {16'd0, b},        32'h0005);
        tick();
        check("bp_empty",        {31'd0, out_valid}, 32'd0);

        // ---- reset with two words buffered ----
        out_ready = 1'b0; in_valid = 1'b1; in_signed = 1'b1;
        a = 32'h0001_2345;
        tick();
        a = 32'd2;
        tick();
        in_valid = 1'b0;
        check("pre_rst_full",  {31'd0, in_ready},  32'd0);
        check("pre_rst_count", {30'd0, ovf_count}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_valid",  {31'd0, out_valid},  32'd0);
        check("mid_rst_ready",  {31'd0, in_ready},   32'd1);
        check("mid_rst_count",  {30'd0, ovf_count},  32'd0);
        check("mid_rst_sticky", {31'd0, ovf_sticky}, 32'd0);
        check("mid_rst_b",      {16'd0, b},          32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("no_stale_%0d", i), {31'd0, out_valid}, 32'd0);
        end

        check("sb_queue_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
